data_ram_ctrl: RTL

- Data-memory controller that sits directly downstream of the core's memory-access port. It serves load and store requests against an internal word array.
- Byte-lane writes are big-endian, matching MIPS byte ordering.
- Access latency is configurable through wait states. A stall request tells the pipeline controller to hold all stages until the access completes.

---
 rtl/data_ram_ctrl_if.sv | 23 ++
 rtl/data_ram_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctrl_if.sv
// Core <-> data-memory controller request/response bundle.
// master = core side, slave = controller side.
interface data_ram_ctrl_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        stallreq_o;
    logic        err_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, ready_o, stallreq_o, err_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, ready_o, stallreq_o, err_o
    );
endinterface

// File: rtl/data_ram_ctrl.sv
// Wait-stated data-memory controller with big-endian byte-lane stores.
// Optional alignment check: define DATA_RAM_CTRL_ALIGN_CHK_EN.
module data_ram_ctrl #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    data_ram_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                w_accept;
    logic                w_commit;

    logic                r_we;
    logic [ADDR_W-1:0]   r_word;
    logic [3:0]          r_sel;
    logic [31:0]         r_wdata;

    logic                w_we;
    logic [ADDR_W-1:0]   w_word;
    logic [3:0]          w_sel;
    logic [31:0]         w_wdata;
    logic                w_bad;

    logic                r_ready;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [2**ADDR_W];

    logic                w_unused;
    assign w_unused = &{1'b0, bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // w_commit marks the IDLE/WAIT->DONE edge: the single point where the access takes effect
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ce_i) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.ce_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_word  <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= bus.we_i;
            r_word  <= bus.addr_i[ADDR_W+1:2];
            r_sel   <= bus.sel_i;
            r_wdata <= bus.data_i;
        end
    end

    // Zero-wait accesses commit in the accept cycle, before the latch is loaded
    assign w_we    = (r_state == S_IDLE) ? bus.we_i                 : r_we;
    assign w_word  = (r_state == S_IDLE) ? bus.addr_i[ADDR_W+1:2]   : r_word;
    assign w_sel   = (r_state == S_IDLE) ? bus.sel_i                : r_sel;
    assign w_wdata = (r_state == S_IDLE) ? bus.data_i               : r_wdata;

`ifdef DATA_RAM_CTRL_ALIGN_CHK_EN
    logic w_bad_in;
    logic r_bad;
    logic r_err;

    always_comb begin
        w_bad_in = 1'b0;
        if (bus.sel_i == 4'b1111 && bus.addr_i[1:0] != 2'b00)
            w_bad_in = 1'b1;
        else if ((bus.sel_i == 4'b0011 || bus.sel_i == 4'b1100) && bus.addr_i[0])
            w_bad_in = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_accept)
                r_bad <= w_bad_in;
            r_err <= w_commit & w_bad;
        end
    end

    assign w_bad     = (r_state == S_IDLE) ? w_bad_in : r_bad;
    assign bus.err_o = r_err;
`else
    assign w_bad     = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    // Lane 3 (bits 31:24) is byte offset 0: big-endian
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_bad) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_sel[i])
                    r_mem[w_word][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_commit;
            if (w_commit && !w_we)
                r_rdata <= w_bad ? '0 : r_mem[w_word];
        end
    end

    assign bus.ready_o    = r_ready;
    assign bus.data_o     = r_rdata;
    assign bus.stallreq_o = bus.ce_i & ~r_ready & rst;

endmodule
